// File: rtl/rf68000_addsub_seq_if.sv
// Operand/result bundle for the byte-serial ADD/SUB sequencer.
// abort_i exists only when RF68000_ADDSEQ_ABORT_EN is defined.
interface rf68000_addsub_seq_if;
   logic        start_i;
   logic        op_i;
   logic [1:0]  sz_i;
   logic        ext_i;
   logic        xin_i;
   logic        zin_i;
   logic [31:0] a_i;
   logic [31:0] b_i;
`ifdef RF68000_ADDSEQ_ABORT_EN
   logic        abort_i;
`endif
   logic        busy_o;
   logic        done_o;
   logic [31:0] res_o;
   logic        x_o, n_o, z_o, v_o, c_o;

   modport master (
`ifdef RF68000_ADDSEQ_ABORT_EN
      output abort_i,
`endif
      output start_i, op_i, sz_i, ext_i, xin_i, zin_i, a_i, b_i,
      input  busy_o, done_o, res_o, x_o, n_o, z_o, v_o, c_o
   );

   modport slave (
`ifdef RF68000_ADDSEQ_ABORT_EN
      input  abort_i,
`endif
      input  start_i, op_i, sz_i, ext_i, xin_i, zin_i, a_i, b_i,
      output busy_o, done_o, res_o, x_o, n_o, z_o, v_o, c_o
   );
endinterface

// File: rtl/rf68000_addsub_seq.sv
// Byte-serial ADD/SUB/ADDX/SUBX sequencer producing 68000 CCR flags X,N,Z,V,C.
// Optional cancel input enabled by defining RF68000_ADDSEQ_ABORT_EN.
module rf68000_addsub_seq (
   input logic                  clk_i,
   input logic                  rst_ni,
   rf68000_addsub_seq_if.slave  bus
);
   typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

   state_e      r_state, w_state_d;
   logic        r_op, r_ext, r_zin, r_carry;
   logic [1:0]  r_idx, r_last;
   logic [31:0] r_a, r_b, r_res;
   logic        r_x, r_n, r_z, r_v, r_c;

   logic        w_abort, w_start, w_last, w_busy, w_done, w_zero, w_vo;
   logic [7:0]  w_da, w_db;
   logic [8:0]  w_sum;
   logic [31:0] w_res, w_mask;

`ifdef RF68000_ADDSEQ_ABORT_EN
   assign w_abort = bus.abort_i & (r_state != StIdle);
`else
   assign w_abort = 1'b0;
`endif

   assign w_start = (r_state == StIdle) & bus.start_i;
   assign w_last  = (r_state == StRun) & (r_idx == r_last);
   assign w_da    = r_a[{r_idx, 3'b000} +: 8];
   assign w_db    = r_b[{r_idx, 3'b000} +: 8];

   // Byte adder/subtractor; bit 8 is carry out (add) or borrow out (sub).
   always_comb begin
      if (r_op) begin
         w_sum = {1'b0, w_da} - {1'b0, w_db} - {8'd0, r_carry};
         w_vo  = (w_da[7] != w_db[7]) & (w_sum[7] != w_da[7]);
      end else begin
         w_sum = {1'b0, w_da} + {1'b0, w_db} + {8'd0, r_carry};
         w_vo  = (w_da[7] == w_db[7]) & (w_sum[7] != w_da[7]);
      end
   end

   always_comb begin
      w_res = r_res;
      w_res[{r_idx, 3'b000} +: 8] = w_sum[7:0];
      unique case (r_last)
         2'd0:    w_mask = 32'h0000_00FF;
         2'd1:    w_mask = 32'h0000_FFFF;
         default: w_mask = 32'hFFFF_FFFF;
      endcase
      w_zero = ~|(w_res & w_mask);
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) r_state <= StIdle;
      else         r_state <= w_state_d;
   end

   always_comb begin
      w_state_d = r_state;
      w_busy    = (r_state != StIdle);
      w_done    = 1'b0;
      unique case (r_state)
         StIdle: if (w_start) w_state_d = StRun;
         StRun: begin
            if (w_abort)     w_state_d = StIdle;
            else if (w_last) w_state_d = StDone;
         end
         StDone: begin
            w_done    = ~w_abort;
            w_state_d = StIdle;
         end
         default: w_state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_op    <= 1'b0;
         r_ext   <= 1'b0;
         r_zin   <= 1'b0;
         r_carry <= 1'b0;
         r_idx   <= 2'd0;
         r_last  <= 2'd0;
         r_a     <= 32'd0;
         r_b     <= 32'd0;
         r_res   <= 32'd0;
         r_x     <= 1'b0;
         r_n     <= 1'b0;
         r_z     <= 1'b0;
         r_v     <= 1'b0;
         r_c     <= 1'b0;
      end else if (w_start) begin
         r_op    <= bus.op_i;
         r_ext   <= bus.ext_i;
         r_zin   <= bus.zin_i;
         r_carry <= bus.ext_i & bus.xin_i;
         r_idx   <= 2'd0;
         r_last  <= (bus.sz_i == 2'b00) ? 2'd0 : (bus.sz_i == 2'b01) ? 2'd1 : 2'd3;
         r_a     <= bus.a_i;
         r_b     <= bus.b_i;
         r_res   <= bus.a_i;
      end else if ((r_state == StRun) && !w_abort) begin
         r_res   <= w_res;
         r_carry <= w_sum[8];
         r_idx   <= r_idx + 2'd1;
         if (w_last) begin
            r_x <= w_sum[8];
            r_c <= w_sum[8];
            r_v <= w_vo;
            r_n <= w_sum[7];
            // Extended ops only clear Z, never set it.
            r_z <= w_zero & (~r_ext | r_zin);
         end
      end
   end

   assign bus.busy_o = w_busy;
   assign bus.done_o = w_done;
   assign bus.res_o  = r_res;
   assign bus.x_o    = r_x;
   assign bus.n_o    = r_n;
   assign bus.z_o    = r_z;
   assign bus.v_o    = r_v;
   assign bus.c_o    = r_c;
endmodule

// File: tb/tb_rf68000_addsub_seq.sv
// Scoreboard bench for rf68000_addsub_seq: directed cases, random ops, reset and abort.
module tb_rf68000_addsub_seq;
   typedef struct packed {
      logic [31:0] res;
      logic        x, n, z, v, c;
      logic [31:0] cyc;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   int unsigned cyc = 0;
   int          n_cmp = 0;
   int          n_bad = 0;
   exp_t        q[$];
   exp_t        last_e = '0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   rf68000_addsub_seq_if bus ();
   rf68000_addsub_seq dut (.clk_i(clk), .rst_ni(rst_n), .bus(bus));

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference: whole-operand arithmetic at the selected width.
   function automatic exp_t model(input logic op, input logic [1:0] sz, input logic ext,
                                  input logic xin, input logic zin, input logic [31:0] a,
                                  input logic [31:0] b, input int unsigned c0);
      int          n  = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
      logic [63:0] mask = (64'd1 << (8 * n)) - 64'd1;
      logic [63:0] am = {32'd0, a} & mask;
      logic [63:0] bm = {32'd0, b} & mask;
      logic [63:0] ci = {63'd0, ext & xin};
      logic [63:0] full, r;
      logic        c, sa, sb, sr;
      exp_t        e;
      if (!op) begin
         full = am + bm + ci;
         c    = full[8 * n];
      end else begin
         full = am - bm - ci;
         c    = (am < bm + ci);
      end
      r  = full & mask;
      sa = am[8 * n - 1];
      sb = bm[8 * n - 1];
      sr = r[8 * n - 1];
      e.res = (a & ~mask[31:0]) | r[31:0];
      e.x   = c;
      e.c   = c;
      e.n   = sr;
      e.v   = op ? ((sa != sb) && (sr != sa)) : ((sa == sb) && (sr != sa));
      e.z   = (r == 64'd0) && (!ext || zin);
      e.cyc = c0 + n;
      return e;
   endfunction

   function automatic exp_t mk(input logic [31:0] res, input logic x, input logic n,
                               input logic z, input logic v, input logic c,
                               input int unsigned dcyc);
      exp_t e;
      e.res = res; e.x = x; e.n = n; e.z = z; e.v = v; e.c = c; e.cyc = dcyc;
      return e;
   endfunction

   always @(negedge clk) begin
      if (rst_n && bus.done_o) begin
         if (q.size() == 0) begin
            chk("unexpected_done", 32'd1, 32'd0);
         end else begin
            exp_t e;
            e = q.pop_front();
            chk("done_cycle", cyc, e.cyc);
            chk("res", bus.res_o, e.res);
            chk("flag_x", {31'd0, bus.x_o}, {31'd0, e.x});
            chk("flag_n", {31'd0, bus.n_o}, {31'd0, e.n});
            chk("flag_z", {31'd0, bus.z_o}, {31'd0, e.z});
            chk("flag_v", {31'd0, bus.v_o}, {31'd0, e.v});
            chk("flag_c", {31'd0, bus.c_o}, {31'd0, e.c});
         end
      end
   end

   task automatic wait_idle();
      int k = 0;
      while (bus.busy_o && k < 200) begin
         @(negedge clk);
         k++;
      end
      if (k >= 200) chk("idle_timeout", 32'd1, 32'd0);
   endtask

   // Issue one op; c0 is the cycle count right after the start edge.
   task automatic issue(input logic op, input logic [1:0] sz, input logic ext, input logic xin,
                        input logic zin, input logic [31:0] a, input logic [31:0] b,
                        input bit push, output int unsigned c0);
      wait_idle();
      @(negedge clk);
      bus.op_i = op; bus.sz_i = sz; bus.ext_i = ext; bus.xin_i = xin; bus.zin_i = zin;
      bus.a_i = a; bus.b_i = b; bus.start_i = 1'b1;
      @(posedge clk);
      #1;
      bus.start_i = 1'b0;
      c0 = cyc;
      if (push) begin
         last_e = model(op, sz, ext, xin, zin, a, b, c0);
         q.push_back(last_e);
      end
   endtask

   initial begin
      int unsigned c0;
      bus.start_i = 1'b0; bus.op_i = 1'b0; bus.sz_i = 2'd0; bus.ext_i = 1'b0;
      bus.xin_i = 1'b0; bus.zin_i = 1'b0; bus.a_i = 32'd0; bus.b_i = 32'd0;
`ifdef RF68000_ADDSEQ_ABORT_EN
      bus.abort_i = 1'b0;
`endif
      #12;
      chk("rst_busy", {31'd0, bus.busy_o}, 32'd0);
      chk("rst_done", {31'd0, bus.done_o}, 32'd0);
      chk("rst_res", bus.res_o, 32'd0);
      chk("rst_flags", {27'd0, bus.x_o, bus.n_o, bus.z_o, bus.v_o, bus.c_o}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // Directed cases with hand-derived results; done lands N edges after the start edge.
      issue(1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 32'h0000_007F, 32'h0000_0001, 0, c0);
      q.push_back(mk(32'h0000_0080, 0, 1, 0, 1, 0, c0 + 1));
      issue(1'b1, 2'd1, 1'b0, 1'b0, 1'b0, 32'h1234_0000, 32'h0000_0001, 0, c0);
      q.push_back(mk(32'h1234_FFFF, 1, 1, 0, 0, 1, c0 + 2));
      issue(1'b0, 2'd2, 1'b1, 1'b1, 1'b1, 32'hFFFF_FFFF, 32'h0000_0000, 0, c0);
      q.push_back(mk(32'h0000_0000, 1, 0, 1, 0, 1, c0 + 4));
      issue(1'b0, 2'd2, 1'b1, 1'b1, 1'b0, 32'hFFFF_FFFF, 32'h0000_0000, 0, c0);
      q.push_back(mk(32'h0000_0000, 1, 0, 0, 0, 1, c0 + 4));
      issue(1'b1, 2'd2, 1'b1, 1'b1, 1'b0, 32'h8000_0000, 32'h0000_0000, 0, c0);
      q.push_back(mk(32'h7FFF_FFFF, 0, 0, 0, 1, 0, c0 + 4));

      // start_i held high: one long op accepted every 6 cycles.
      wait_idle();
      @(negedge clk);
      bus.start_i = 1'b1;
      @(posedge clk);
      #1;
      c0 = cyc;
      for (int k = 0; k < 3; k++) q.push_back(mk(32'h7FFF_FFFF, 0, 0, 0, 1, 0, c0 + k * 6 + 4));
      repeat (17) @(posedge clk);
      @(negedge clk);
      bus.start_i = 1'b0;

      for (int i = 0; i < 40; i++) begin
         logic [31:0] a, b;
         logic        op;
         a  = $urandom;
         b  = $urandom;
         op = 1'($urandom_range(0, 1));
         if ($urandom_range(0, 3) == 0) b = a;
         issue(op, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
               1'($urandom_range(0, 1)), a, b, 1, c0);
      end

      // Reset in the middle of a long op clears everything at once.
      issue(1'b0, 2'd2, 1'b0, 1'b0, 1'b0, 32'h0101_0101, 32'h0202_0202, 0, c0);
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      chk("mid_rst_busy", {31'd0, bus.busy_o}, 32'd0);
      chk("mid_rst_done", {31'd0, bus.done_o}, 32'd0);
      chk("mid_rst_res", bus.res_o, 32'd0);
      chk("mid_rst_flags", {27'd0, bus.x_o, bus.n_o, bus.z_o, bus.v_o, bus.c_o}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      last_e = '0;
      repeat (10) @(negedge clk);
      chk("post_rst_busy", {31'd0, bus.busy_o}, 32'd0);

`ifdef RF68000_ADDSEQ_ABORT_EN
      issue(1'b1, 2'd2, 1'b0, 1'b0, 1'b0, 32'h0000_0000, 32'h0000_0000, 0, c0);
      @(posedge clk);
      #1;
      bus.abort_i = 1'b1;
      @(posedge clk);
      #1;
      bus.abort_i = 1'b0;
      chk("abort_busy", {31'd0, bus.busy_o}, 32'd0);
      chk("abort_flags", {27'd0, bus.x_o, bus.n_o, bus.z_o, bus.v_o, bus.c_o},
          {27'd0, last_e.x, last_e.n, last_e.z, last_e.v, last_e.c});
      issue(1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 32'h0000_00F0, 32'h0000_0020, 1, c0);
`endif

      wait_idle();
      repeat (3) @(negedge clk);
      chk("queue_empty", q.size(), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
